// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-memory / MMIO subsystem: peripheral offsets,
// status-register bit positions and the page-match helper.
package dmem_mmio_pkg;

  localparam logic [15:0] OFF_LEDS   = 16'h0000;
  localparam logic [15:0] OFF_CYCLE  = 16'h0004;
  localparam logic [15:0] OFF_TIMER  = 16'h0008;
  localparam logic [15:0] OFF_TSTAT  = 16'h000C;
  localparam logic [15:0] OFF_TXDATA = 16'h0010;
  localparam logic [15:0] OFF_TXSTAT = 16'h0014;

  localparam int unsigned EXPIRED_BIT = 0;
  localparam int unsigned FULL_BIT    = 0;
  localparam int unsigned EMPTY_BIT   = 1;
  localparam int unsigned CNT_LSB     = 2;
  localparam int unsigned OVF_BIT     = 5;

  // The peripheral page is 64 KiB, so only the upper halfword takes part in the match.
  function automatic logic page_match(input logic [15:0] addr_hi, input logic [15:0] base_hi);
    return addr_hi == base_hi;
  endfunction

endpackage

// File: rtl/dmem_mmio_tx_fifo.sv
// Byte transmit FIFO. A push is judged against the occupancy at the start of the
// cycle, so a full FIFO rejects a push even when a pop happens in the same cycle.
module tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [7:0]               i_push_data,
  input  logic                     i_pop,
  output logic [7:0]               o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_push_rejected
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full          = (r_count == (PW+1)'(DEPTH));
  assign o_empty         = (r_count == '0);
  assign o_count         = r_count;
  assign o_head          = r_mem[r_rd_ptr];
  assign w_push_ok       = i_push && !o_full;
  assign w_pop_ok        = i_pop && !o_empty;
  assign o_push_rejected = i_push && o_full;

  // Storage is cleared too so the head output is defined straight after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 8'h00;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{PW{1'b0}}, w_push_ok} - {{PW{1'b0}}, w_pop_ok};
    end
  end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory for the single-cycle core: word RAM plus a peripheral page
// (LEDs, cycle counter, countdown timer, TX FIFO). Loads are combinational.
module dmem_mmio
  import dmem_mmio_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 256,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int unsigned TX_DEPTH  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_dmem_we,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_wdata,
  output logic [31:0] o_dmem_rdata,
  output logic [7:0]  o_leds,
  output logic        o_timer_irq,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready
);

  localparam int unsigned AW = $clog2(RAM_WORDS);
  localparam int unsigned CW = $clog2(TX_DEPTH) + 1;

  logic [31:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_leds;
  logic [31:0]   r_cycle;
  logic [31:0]   r_timer;
  logic          r_expired;
  logic          r_ovf;

  logic          w_is_mmio;
  logic [15:0]   w_off;
  logic [AW-1:0] w_ram_idx;
  logic          w_mmio_we;
  logic          w_wr_leds;
  logic          w_wr_timer;
  logic          w_wr_tstat;
  logic          w_wr_txdata;
  logic          w_wr_txstat;
  logic          w_set_expired;
  logic          w_tx_pop;
  logic [7:0]    w_tx_head;
  logic [CW-1:0] w_tx_count;
  logic          w_tx_full;
  logic          w_tx_empty;
  logic          w_tx_rejected;
  logic [31:0]   w_txstat;
  logic [31:0]   w_mmio_rdata;

  assign w_is_mmio   = page_match(i_dmem_addr[31:16], MMIO_BASE[31:16]);
  assign w_off       = i_dmem_addr[15:0] & 16'hFFFC;
  assign w_ram_idx   = i_dmem_addr[AW+1:2];
  assign w_mmio_we   = i_dmem_we && w_is_mmio;
  assign w_wr_leds   = w_mmio_we && (w_off == OFF_LEDS);
  assign w_wr_timer  = w_mmio_we && (w_off == OFF_TIMER);
  assign w_wr_tstat  = w_mmio_we && (w_off == OFF_TSTAT);
  assign w_wr_txdata = w_mmio_we && (w_off == OFF_TXDATA);
  assign w_wr_txstat = w_mmio_we && (w_off == OFF_TXSTAT);

  // A load in the same cycle cancels both the decrement and the expiry.
  assign w_set_expired = !w_wr_timer && (r_timer == 32'd1);

  assign w_tx_pop    = o_tx_valid && i_tx_ready;
  assign o_tx_valid  = !w_tx_empty;
  assign o_tx_data   = w_tx_head;
  assign o_leds      = r_leds;
  assign o_timer_irq = r_expired;

  tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_push          (w_wr_txdata),
    .i_push_data     (i_dmem_wdata[7:0]),
    .i_pop           (w_tx_pop),
    .o_head          (w_tx_head),
    .o_count         (w_tx_count),
    .o_full          (w_tx_full),
    .o_empty         (w_tx_empty),
    .o_push_rejected (w_tx_rejected)
  );

  // RAM has no reset; its contents are undefined until written.
  always_ff @(posedge i_clk) begin
    if (i_dmem_we && !w_is_mmio) begin
      r_ram[w_ram_idx] <= i_dmem_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_leds    <= 8'h00;
      r_cycle   <= 32'd0;
      r_timer   <= 32'd0;
      r_expired <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if (w_wr_leds) begin
        r_leds <= i_dmem_wdata[7:0];
      end
      if (w_wr_timer) begin
        r_timer <= i_dmem_wdata;
      end else if (r_timer != 32'd0) begin
        r_timer <= r_timer - 32'd1;
      end
      if (w_set_expired) begin
        r_expired <= 1'b1;
      end else if (w_wr_tstat && i_dmem_wdata[EXPIRED_BIT]) begin
        r_expired <= 1'b0;
      end
      if (w_tx_rejected) begin
        r_ovf <= 1'b1;
      end else if (w_wr_txstat && i_dmem_wdata[OVF_BIT]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_comb begin
    w_txstat                    = 32'd0;
    w_txstat[FULL_BIT]          = w_tx_full;
    w_txstat[EMPTY_BIT]         = w_tx_empty;
    w_txstat[CNT_LSB+2:CNT_LSB] = 3'(w_tx_count);
    w_txstat[OVF_BIT]           = r_ovf;
  end

  always_comb begin
    w_mmio_rdata = 32'd0;
    case (w_off)
      OFF_LEDS:   w_mmio_rdata = {24'd0, r_leds};
      OFF_CYCLE:  w_mmio_rdata = r_cycle;
      OFF_TIMER:  w_mmio_rdata = r_timer;
      OFF_TSTAT:  w_mmio_rdata = {31'd0, r_expired};
      OFF_TXSTAT: w_mmio_rdata = w_txstat;
      default:    w_mmio_rdata = 32'd0;
    endcase
  end

  assign o_dmem_rdata = w_is_mmio ? w_mmio_rdata : r_ram[w_ram_idx];

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: directed scenarios followed by random traffic,
// all compared against a queue/array reference model of the memory map.
module tb_dmem_mmio;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_dmem_we = 1'b0;
  logic [31:0] i_dmem_addr = 32'd0;
  logic [31:0] i_dmem_wdata = 32'd0;
  logic        i_tx_ready = 1'b0;
  logic [31:0] o_dmem_rdata;
  logic [7:0]  o_leds;
  logic        o_timer_irq;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;

  always #5 i_clk = ~i_clk;

  dmem_mmio u_dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_dmem_we    (i_dmem_we),
    .i_dmem_addr  (i_dmem_addr),
    .i_dmem_wdata (i_dmem_wdata),
    .o_dmem_rdata (o_dmem_rdata),
    .o_leds       (o_leds),
    .o_timer_irq  (o_timer_irq),
    .o_tx_data    (o_tx_data),
    .o_tx_valid   (o_tx_valid),
    .i_tx_ready   (i_tx_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int unsigned m_leds;
  int unsigned m_cycle;
  int unsigned m_timer;
  bit          m_exp;
  bit          m_ovf;
  logic [7:0]  m_q[$];
  logic [31:0] m_ram [256];
  bit          m_ram_ok [256];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_leds  = 0;
    m_cycle = 0;
    m_timer = 0;
    m_exp   = 1'b0;
    m_ovf   = 1'b0;
    m_q.delete();
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
    logic [15:0] off;
    off   = a[15:0] & 16'hFFFC;
    known = 1'b1;
    if (a[31:16] == 16'hFFFF) begin
      case (off)
        16'h0000: return m_leds;
        16'h0004: return m_cycle;
        16'h0008: return m_timer;
        16'h000C: return {31'd0, m_exp};
        16'h0014: return {26'd0, m_ovf, 3'(m_q.size()), m_q.size() == 0, m_q.size() == 4};
        default:  return 32'd0;
      endcase
    end
    known = m_ram_ok[a[9:2]];
    return m_ram[a[9:2]];
  endfunction

  function automatic void m_update(input logic we, input logic [31:0] a, input logic [31:0] wd,
                                   input logic rdy, input logic rs);
    bit          mm;
    logic [15:0] off;
    int          sz;
    bit          push;
    bit          load;
    mm  = (a[31:16] == 16'hFFFF);
    off = a[15:0] & 16'hFFFC;
    if (we && !mm) begin
      m_ram[a[9:2]]    = wd;
      m_ram_ok[a[9:2]] = 1'b1;
    end
    if (rs) begin
      m_reset();
      return;
    end
    sz   = m_q.size();
    push = we && mm && off == 16'h0010;
    if (push && sz >= 4) m_ovf = 1'b1;
    else if (we && mm && off == 16'h0014 && wd[5]) m_ovf = 1'b0;
    if (sz > 0 && rdy) void'(m_q.pop_front());
    if (push && sz < 4) m_q.push_back(wd[7:0]);
    load = we && mm && off == 16'h0008;
    if (!load && m_timer == 1) m_exp = 1'b1;
    else if (we && mm && off == 16'h000C && wd[0]) m_exp = 1'b0;
    m_timer = load ? wd : (m_timer > 0 ? m_timer - 1 : 0);
    if (we && mm && off == 16'h0000) m_leds = {24'd0, wd[7:0]};
    m_cycle++;
  endfunction

  // One clock cycle: drive, compare outputs against the model, clock, advance the model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input logic rs, input string tag = "",
                      input logic [31:0] exp = 32'd0);
    logic [31:0] exp_rd;
    bit          known;
    i_dmem_we    = we;
    i_dmem_addr  = a;
    i_dmem_wdata = wd;
    i_tx_ready   = rdy;
    i_rst        = rs;
    #2;
    exp_rd = m_read(a, known);
    if (known) check("rdata", o_dmem_rdata, exp_rd);
    check("leds", {24'd0, o_leds}, m_leds);
    check("timer_irq", 32'(o_timer_irq), 32'(m_exp));
    check("tx_valid", 32'(o_tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("tx_data", {24'd0, o_tx_data}, {24'd0, m_q[0]});
    if (tag != "") check(tag, o_dmem_rdata, exp);
    @(posedge i_clk);
    m_update(we, a, wd, rdy, rs);
    @(negedge i_clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    step(1'b0, a, 32'd0, 1'b0, 1'b0, tag, exp);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0]  drain_exp [4];
    logic [31:0] a;
    logic [15:0] off;
    logic        we;
    logic        rs;
    logic [31:0] wd;

    for (int i = 0; i < 256; i++) m_ram_ok[i] = 1'b0;
    drain_exp[0] = 8'h11;
    drain_exp[1] = 8'h22;
    drain_exp[2] = 8'h33;
    drain_exp[3] = 8'h44;

    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    m_reset();
    check("rst_leds", {24'd0, o_leds}, 32'd0);
    check("rst_irq", 32'(o_timer_irq), 32'd0);
    check("rst_tx_valid", 32'(o_tx_valid), 32'd0);
    check("rst_tx_data", {24'd0, o_tx_data}, 32'd0);

    // Cycle counter and LEDs
    repeat (10) idle(1'b0);
    rd(32'hFFFF_0004, 32'd10, "cycle_10");
    wr(32'hFFFF_0000, 32'h0000_00A5);
    check("leds_a5", {24'd0, o_leds}, 32'h0000_00A5);
    rd(32'hFFFF_0000, 32'h0000_00A5, "leds_rd");

    // RAM and aliasing
    wr(32'h0000_0040, 32'hDEAD_BEEF);
    rd(32'h0000_0040, 32'hDEAD_BEEF, "ram_40");
    rd(32'h0000_0440, 32'hDEAD_BEEF, "ram_alias");
    rd(32'hFFFF_0040, 32'd0, "mmio_unmapped");

    // Timer countdown, sticky expiry, clear, reload at count 1
    wr(32'hFFFF_0008, 32'd3);
    rd(32'hFFFF_0008, 32'd3, "timer_3");
    rd(32'hFFFF_0008, 32'd2, "timer_2");
    rd(32'hFFFF_0008, 32'd1, "timer_1");
    rd(32'hFFFF_0008, 32'd0, "timer_0");
    check("irq_high", 32'(o_timer_irq), 32'd1);
    rd(32'hFFFF_000C, 32'd1, "tstat_set");
    wr(32'hFFFF_000C, 32'd1);
    rd(32'hFFFF_000C, 32'd0, "tstat_clr");
    wr(32'hFFFF_0008, 32'd2);
    rd(32'hFFFF_0008, 32'd2, "timer_re2");
    wr(32'hFFFF_0008, 32'd5);
    rd(32'hFFFF_0008, 32'd5, "timer_reload");
    rd(32'hFFFF_000C, 32'd0, "no_expiry");
    wr(32'hFFFF_0008, 32'd0);

    // FIFO overflow and ordered drain
    for (int k = 1; k <= 5; k++) wr(32'hFFFF_0010, 32'(k * 'h11));
    rd(32'hFFFF_0014, 32'h0000_0031, "txstat_full");
    for (int k = 0; k < 4; k++) begin
      check("drain_order", {24'd0, o_tx_data}, {24'd0, drain_exp[k]});
      idle(1'b1);
    end
    check("drained_valid", 32'(o_tx_valid), 32'd0);
    rd(32'hFFFF_0014, 32'h0000_0022, "txstat_empty_ovf");
    wr(32'hFFFF_0014, 32'h0000_0020);
    rd(32'hFFFF_0014, 32'h0000_0002, "txstat_ovf_clr");

    // Push and pop together on two entries
    wr(32'hFFFF_0010, 32'hAA);
    wr(32'hFFFF_0010, 32'hBB);
    step(1'b1, 32'hFFFF_0010, 32'h66, 1'b1, 1'b0);
    rd(32'hFFFF_0014, 32'h0000_0008, "txstat_cnt2");
    check("pp_head_bb", {24'd0, o_tx_data}, 32'hBB);
    idle(1'b1);
    check("pp_head_66", {24'd0, o_tx_data}, 32'h66);
    idle(1'b1);
    check("pp_drained", 32'(o_tx_valid), 32'd0);

    // Push into a full FIFO while it pops
    for (int k = 1; k <= 4; k++) wr(32'hFFFF_0010, 32'(k));
    step(1'b1, 32'hFFFF_0010, 32'd5, 1'b1, 1'b0);
    rd(32'hFFFF_0014, 32'h0000_002C, "full_pushpop");
    wr(32'hFFFF_0014, 32'h0000_0020);
    repeat (3) idle(1'b1);
    check("fp_drained", 32'(o_tx_valid), 32'd0);

    // Reset mid-drain with the timer running
    wr(32'hFFFF_0010, 32'h07);
    wr(32'hFFFF_0010, 32'h08);
    wr(32'hFFFF_0010, 32'h09);
    wr(32'hFFFF_0008, 32'd20);
    idle(1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    check("rst_mid_valid", 32'(o_tx_valid), 32'd0);
    rd(32'hFFFF_0004, 32'd0, "rst_cycle");
    rd(32'hFFFF_0008, 32'd0, "rst_timer");
    rd(32'hFFFF_000C, 32'd0, "rst_expired");
    rd(32'hFFFF_0014, 32'h0000_0002, "rst_txstat");
    rd(32'h0000_0040, 32'hDEAD_BEEF, "ram_survives_rst");

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 99) < 2);
      we = !rs && ($urandom_range(0, 1) == 1);
      wd = $urandom;
      if ($urandom_range(0, 9) < 4) begin
        a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
        if (a[31:16] == 16'hFFFF) a[31] = 1'b0;
      end else begin
        off = 16'($urandom_range(0, 7) * 4 + $urandom_range(0, 3));
        a   = {16'hFFFF, off};
        if ((off & 16'hFFFC) == 16'h0008) wd = 32'($urandom_range(0, 5));
      end
      step(we, a, wd, ($urandom_range(0, 2) == 0), rs);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
